lsu_arbiter: RTL and testbench
==============================

LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter LD_LATENCY, default 1, cycles from ACCESS entry to valid lsu_ld_data_i; legal values are 1..4.
REQ-002 SHALL have port clock_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_ni, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have ports m0_req_i / m1_req_i, input, 1 bit each: access request per requester (m0 = core, m1 = loader/debug).
REQ-005 SHALL have ports mN_addr_i (input, 32), mN_mode_i (input, 2; 00 byte, 01 half, 10 word), mN_unsigned_i (input, 1), mN_we_i (input, 1) and mN_wdata_i (input, 32): the request payload for N=0,1.
REQ-006 SHALL have ports mN_gnt_o, output, 1 bit: one-cycle grant pulse; payload captured on that edge.
REQ-007 SHALL have ports mN_rvalid_o (output, 1) and mN_rdata_o (output, 32): load response for N=0,1.
REQ-008 SHALL have ports lsu_addr_o (output, 32), lsu_mode_o (output, 2), lsu_unsigned_o (output, 1), lsu_st_en_o (output, 1), lsu_st_data_o (output, 32) and lsu_ld_data_i (input, 32): the shared LSU port.
REQ-009 SHALL have port busy_o, output, 1 bit: high when state is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS and WAIT.
REQ-011 SHALL arbitrate only in IDLE; gnt_o is combinational from req and arbitration state, asserted for at most one port, and only in IDLE.
REQ-012 SHALL, on a granted edge, latch port id and payload into holding registers and enter ACCESS.
REQ-013 SHALL drive the lsu_* outputs from the holding registers in ACCESS and WAIT, holding them stable, and drive all-zero outputs in IDLE.
REQ-014 SHALL assert lsu_st_en_o for exactly the single ACCESS cycle of a store; a store returns ACCESS -> IDLE with no rvalid.
REQ-015 SHALL, for a load, go ACCESS -> IDLE when LD_LATENCY=1, else ACCESS -> WAIT for LD_LATENCY-1 cycles (down-counter) -> IDLE.
REQ-016 SHALL capture lsu_ld_data_i on the edge leaving the last ACCESS/WAIT cycle of a load into the granted port's rdata_o, and pulse that port's rvalid_o high for the next cycle only.
REQ-017 SHALL hold mN_rdata_o until the next load response to that port.
REQ-018 SHALL ignore req while busy; a requester keeps req and payload stable until gnt; a req dropped before gnt causes no access.
REQ-019 SHALL permit a rvalid pulse and a new gnt in the same IDLE cycle, giving back-to-back loads at LD_LATENCY=1 one access per 2 cycles.
REQ-020 SHALL pass mode and unsigned through unmodified, including mode 11, and SHALL not check alignment.

Reset
REQ-021 SHALL, on reset_ni low, immediately force IDLE, holding registers 0, counter 0, all gnt/rvalid/lsu_* outputs 0, rdata 0, and last-grant pointer = 1.
REQ-022 SHALL abort any access in flight on reset, producing no rvalid and deasserting lsu_st_en_o asynchronously.

Configuration
REQ-023 SHALL use macro LSU_ARB_ROUND_ROBIN_EN: when defined, on simultaneous requests grant the port not equal to the last-grant pointer, updating the pointer on every grant.
REQ-024 SHALL, without LSU_ARB_ROUND_ROBIN_EN, use fixed priority (m0 always wins a tie) and have no pointer.

Verification
REQ-025 Bench SHALL cover: m0 store word addr 0x10 data 0xDEADBEEF -> m0_gnt 1 cycle, next cycle lsu_st_en_o=1 with addr 0x10, then IDLE, no rvalid.
REQ-026 Bench SHALL cover: m1 load byte signed, lsu_ld_data_i=0x00000080, LD_LATENCY=1 -> m1_rvalid_o pulse 2 cycles after gnt, m1_rdata_o=0x00000080 (passthrough).
REQ-027 Bench SHALL cover: both req held 4 accesses with RR macro defined -> grants m0,m1,m0,m1; without the macro -> m0 x4 and m1 starved.
REQ-028 Bench SHALL cover: LD_LATENCY=3 load -> busy_o high 3 cycles, rvalid on the 4th cycle after gnt, lsu_addr_o stable throughout.
REQ-029 Bench SHALL cover: reset_ni low during WAIT -> outputs 0 same cycle, no rvalid, first grant after release goes to m0 on a tie.
REQ-030 Bench SHALL cover: req asserted while busy -> no gnt until IDLE; req dropped before gnt -> lsu_st_en_o never asserted.

Source files
------------

// File: rtl/lsu_arbiter.sv
// ============================================================================
// lsu_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares a single load/store unit (LSU) port between two requesters:
//   m0 (the core) and m1 (the loader/debug path). Arbitration happens only
//   while idle. A granted request is copied into holding registers and
//   replayed on the shared LSU port for the length of the access. Loads
//   return their data to the requester that issued them, together with a
//   one-cycle rvalid pulse.
//
// Parameters:
//   LD_LATENCY  cycles from ACCESS entry until lsu_ld_data_i is valid (1..4)
//
// Configuration macro:
//   LSU_ARB_ROUND_ROBIN_EN  defined   -> round-robin on simultaneous requests
//                           undefined -> fixed priority, m0 wins every tie
//
// Ports:
//   clock_i         clock, all state changes on the rising edge
//   reset_ni        asynchronous active-low reset
//   mN_req_i        access request from requester N (N = 0, 1)
//   mN_addr_i       byte address
//   mN_mode_i       access size: 00 byte, 01 half, 10 word (11 passed through)
//   mN_unsigned_i   zero-extend load data (passed through, not interpreted)
//   mN_we_i         1 = store, 0 = load
//   mN_wdata_i      store data
//   mN_gnt_o        one-cycle grant, payload captured on that clock edge
//   mN_rvalid_o     one-cycle load response pulse
//   mN_rdata_o      load data, held until the next response to that port
//   lsu_addr_o      shared LSU address
//   lsu_mode_o      shared LSU access size
//   lsu_unsigned_o  shared LSU unsigned flag
//   lsu_st_en_o     store enable, high for the single ACCESS cycle of a store
//   lsu_st_data_o   store data
//   lsu_ld_data_i   load data returned by the LSU
//   busy_o          high whenever the arbiter is not IDLE
// ============================================================================
module lsu_arbiter #(
    parameter int unsigned LD_LATENCY = 1
) (
    input  logic        clock_i,
    input  logic        reset_ni,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic [1:0]  m0_mode_i,
    input  logic        m0_unsigned_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic [1:0]  m1_mode_i,
    input  logic        m1_unsigned_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic [31:0] lsu_addr_o,
    output logic [1:0]  lsu_mode_o,
    output logic        lsu_unsigned_o,
    output logic        lsu_st_en_o,
    output logic [31:0] lsu_st_data_o,
    input  logic [31:0] lsu_ld_data_i,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // WAIT lasts LD_LATENCY-1 cycles; the counter counts down to zero in the
    // final WAIT cycle, so it is preloaded with LD_LATENCY-2.
    localparam logic [1:0] WAIT_INIT = (LD_LATENCY > 1) ? 2'(LD_LATENCY - 2) : 2'd0;

    state_t      r_state;
    logic        r_port;        // 0 = m0 owns the access, 1 = m1
    logic [31:0] r_addr;
    logic [1:0]  r_mode;
    logic        r_unsigned;
    logic        r_we;
    logic [31:0] r_wdata;
    logic        r_st_en;
    logic [1:0]  r_cnt;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_grant;
    logic [31:0] w_addr;
    logic [1:0]  w_mode;
    logic        w_unsigned;
    logic        w_we;
    logic [31:0] w_wdata;
    logic        w_done;
    logic        w_capture;

`ifdef LSU_ARB_ROUND_ROBIN_EN
    // Last port granted; a tie goes to the other port. Reset value 1 makes
    // the first tie after reset go to m0.
    logic        r_last_gnt;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == IDLE) begin
            if (m0_req_i && m1_req_i) begin
                w_gnt0 = r_last_gnt;
                w_gnt1 = ~r_last_gnt;
            end else begin
                w_gnt0 = m0_req_i;
                w_gnt1 = m1_req_i;
            end
        end
    end
`else
    // Fixed priority: m0 always wins a tie.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == IDLE) begin
            w_gnt0 = m0_req_i;
            w_gnt1 = m1_req_i & ~m0_req_i;
        end
    end
`endif

    assign w_grant = w_gnt0 | w_gnt1;

    // Payload of whichever port is being granted this cycle.
    assign w_addr     = w_gnt1 ? m1_addr_i     : m0_addr_i;
    assign w_mode     = w_gnt1 ? m1_mode_i     : m0_mode_i;
    assign w_unsigned = w_gnt1 ? m1_unsigned_i : m0_unsigned_i;
    assign w_we       = w_gnt1 ? m1_we_i       : m0_we_i;
    assign w_wdata    = w_gnt1 ? m1_wdata_i    : m0_wdata_i;

    // Last cycle of an access: a store or a single-cycle load ends in ACCESS;
    // a longer load ends when the WAIT counter reaches zero.
    assign w_done = ((r_state == ACCESS) && (r_we || (LD_LATENCY <= 1))) ||
                    ((r_state == WAIT) && (r_cnt == 2'd0));
    assign w_capture = w_done & ~r_we;

    // Holding registers are cleared when an access ends, so the LSU port
    // reads as all-zero whenever the arbiter is idle.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= IDLE;
            r_port     <= 1'b0;
            r_addr     <= '0;
            r_mode     <= '0;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_st_en    <= 1'b0;
            r_cnt      <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
`ifdef LSU_ARB_ROUND_ROBIN_EN
            r_last_gnt <= 1'b1;
`endif
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state    <= ACCESS;
                        r_port     <= w_gnt1;
                        r_addr     <= w_addr;
                        r_mode     <= w_mode;
                        r_unsigned <= w_unsigned;
                        r_we       <= w_we;
                        r_wdata    <= w_wdata;
                        r_st_en    <= w_we;
                        r_cnt      <= WAIT_INIT;
`ifdef LSU_ARB_ROUND_ROBIN_EN
                        r_last_gnt <= w_gnt1;
`endif
                    end
                end
                ACCESS: begin
                    r_st_en <= 1'b0;
                    if (!w_done) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!w_done) begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Ending an access overrides the per-state updates above.
            if (w_done) begin
                r_state    <= IDLE;
                r_port     <= 1'b0;
                r_addr     <= '0;
                r_mode     <= '0;
                r_unsigned <= 1'b0;
                r_we       <= 1'b0;
                r_wdata    <= '0;
                r_st_en    <= 1'b0;
                r_cnt      <= '0;
            end

            // Load data is routed to the port that owns the access.
            if (w_capture) begin
                if (r_port) begin
                    r_rdata1  <= lsu_ld_data_i;
                    r_rvalid1 <= 1'b1;
                end else begin
                    r_rdata0  <= lsu_ld_data_i;
                    r_rvalid0 <= 1'b1;
                end
            end
        end
    end

    assign m0_gnt_o       = w_gnt0;
    assign m1_gnt_o       = w_gnt1;
    assign m0_rvalid_o    = r_rvalid0;
    assign m1_rvalid_o    = r_rvalid1;
    assign m0_rdata_o     = r_rdata0;
    assign m1_rdata_o     = r_rdata1;

    assign lsu_addr_o     = r_addr;
    assign lsu_mode_o     = r_mode;
    assign lsu_unsigned_o = r_unsigned;
    assign lsu_st_en_o    = r_st_en;
    assign lsu_st_data_o  = r_wdata;

    assign busy_o         = (r_state != IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// ============================================================================
// tb_lsu_arbiter
// ----------------------------------------------------------------------------
// Two arbiters share every input: dutA is built with LD_LATENCY=1 and dutB
// with LD_LATENCY=3. Stores take the same time on both, so scenarios that
// only issue stores keep the two instances in lockstep. Inputs change one
// time unit after the rising edge and outputs are sampled on the falling
// edge. Expected arbitration order follows LSU_ARB_ROUND_ROBIN_EN.
// ============================================================================
module tb_lsu_arbiter;

    logic        clock = 1'b0;
    logic        resetN;

    logic        m0Req, m0Unsigned, m0We;
    logic [31:0] m0Addr, m0Wdata;
    logic [1:0]  m0Mode;
    logic        m1Req, m1Unsigned, m1We;
    logic [31:0] m1Addr, m1Wdata;
    logic [1:0]  m1Mode;
    logic [31:0] ldData;

    logic        aM0Gnt, aM1Gnt, aM0Rvalid, aM1Rvalid, aLsuUnsigned, aLsuStEn, aBusy;
    logic [31:0] aM0Rdata, aM1Rdata, aLsuAddr, aLsuStData;
    logic [1:0]  aLsuMode;
    logic        bM0Gnt, bM1Gnt, bM0Rvalid, bM1Rvalid, bLsuUnsigned, bLsuStEn, bBusy;
    logic [31:0] bM0Rdata, bM1Rdata, bLsuAddr, bLsuStData;
    logic [1:0]  bLsuMode;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clock = ~clock;

    lsu_arbiter #(.LD_LATENCY(1)) dutA (
        .clock_i(clock), .reset_ni(resetN),
        .m0_req_i(m0Req), .m0_addr_i(m0Addr), .m0_mode_i(m0Mode),
        .m0_unsigned_i(m0Unsigned), .m0_we_i(m0We), .m0_wdata_i(m0Wdata),
        .m0_gnt_o(aM0Gnt), .m0_rvalid_o(aM0Rvalid), .m0_rdata_o(aM0Rdata),
        .m1_req_i(m1Req), .m1_addr_i(m1Addr), .m1_mode_i(m1Mode),
        .m1_unsigned_i(m1Unsigned), .m1_we_i(m1We), .m1_wdata_i(m1Wdata),
        .m1_gnt_o(aM1Gnt), .m1_rvalid_o(aM1Rvalid), .m1_rdata_o(aM1Rdata),
        .lsu_addr_o(aLsuAddr), .lsu_mode_o(aLsuMode), .lsu_unsigned_o(aLsuUnsigned),
        .lsu_st_en_o(aLsuStEn), .lsu_st_data_o(aLsuStData), .lsu_ld_data_i(ldData),
        .busy_o(aBusy)
    );

    lsu_arbiter #(.LD_LATENCY(3)) dutB (
        .clock_i(clock), .reset_ni(resetN),
        .m0_req_i(m0Req), .m0_addr_i(m0Addr), .m0_mode_i(m0Mode),
        .m0_unsigned_i(m0Unsigned), .m0_we_i(m0We), .m0_wdata_i(m0Wdata),
        .m0_gnt_o(bM0Gnt), .m0_rvalid_o(bM0Rvalid), .m0_rdata_o(bM0Rdata),
        .m1_req_i(m1Req), .m1_addr_i(m1Addr), .m1_mode_i(m1Mode),
        .m1_unsigned_i(m1Unsigned), .m1_we_i(m1We), .m1_wdata_i(m1Wdata),
        .m1_gnt_o(bM1Gnt), .m1_rvalid_o(bM1Rvalid), .m1_rdata_o(bM1Rdata),
        .lsu_addr_o(bLsuAddr), .lsu_mode_o(bLsuMode), .lsu_unsigned_o(bLsuUnsigned),
        .lsu_st_en_o(bLsuStEn), .lsu_st_data_o(bLsuStData), .lsu_ld_data_i(ldData),
        .busy_o(bBusy)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait for the falling edge, where outputs are sampled.
    task automatic sample();
        @(negedge clock);
    endtask

    // Drive one requester's request line and payload.
    task automatic applyStimulus(input bit port, input bit req, input bit we,
                                 input logic [31:0] addr, input logic [1:0] mode,
                                 input bit uns, input logic [31:0] wdata);
        if (port) begin
            m1Req = req; m1We = we; m1Addr = addr; m1Mode = mode;
            m1Unsigned = uns; m1Wdata = wdata;
        end else begin
            m0Req = req; m0We = we; m0Addr = addr; m0Mode = mode;
            m0Unsigned = uns; m0Wdata = wdata;
        end
    endtask

    // Outputs while reset is held, then release.
    task automatic test_reset();
        #2;
        sample();
        checkCount++;
        if ({aM0Gnt, aM1Gnt, aM0Rvalid, aM1Rvalid, aLsuStEn, aBusy, aLsuMode, aLsuUnsigned} !== 9'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_ctrl_a got %b expected 0",
                     {aM0Gnt, aM1Gnt, aM0Rvalid, aM1Rvalid, aLsuStEn, aBusy, aLsuMode, aLsuUnsigned});
        end
        checkCount++;
        if ({aLsuAddr, aLsuStData, aM0Rdata, aM1Rdata} !== 128'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_data_a got %h expected 0", {aLsuAddr, aLsuStData, aM0Rdata, aM1Rdata});
        end
        checkCount++;
        if ({bM0Gnt, bM1Gnt, bM0Rvalid, bM1Rvalid, bLsuStEn, bBusy, bLsuAddr, bM0Rdata, bM1Rdata} !== 102'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_b got %h expected 0",
                     {bM0Gnt, bM1Gnt, bM0Rvalid, bM1Rvalid, bLsuStEn, bBusy, bLsuAddr, bM0Rdata, bM1Rdata});
        end
        step();
        resetN = 1'b1;
        step();
    endtask

    // m0 word store: one grant cycle, one store-enable cycle, no response.
    task automatic test_store();
        applyStimulus(0, 1, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF);
        sample();
        checkCount++;
        if ({aM0Gnt, aM1Gnt, aBusy} !== 3'b100) begin
            errorCount++;
            $display("[TB] FAIL store_gnt got %b expected 100", {aM0Gnt, aM1Gnt, aBusy});
        end
        step();
        m0Req = 1'b0;
        sample();
        checkCount++;
        if ({aM0Gnt, aLsuStEn, aBusy, aM0Rvalid} !== 4'b0110) begin
            errorCount++;
            $display("[TB] FAIL store_access_ctrl got %b expected 0110", {aM0Gnt, aLsuStEn, aBusy, aM0Rvalid});
        end
        checkCount++;
        if ({aLsuAddr, aLsuStData, aLsuMode} !== {32'h10, 32'hDEADBEEF, 2'b10}) begin
            errorCount++;
            $display("[TB] FAIL store_access_data got %h %h %b expected 00000010 deadbeef 10",
                     aLsuAddr, aLsuStData, aLsuMode);
        end
        step();
        sample();
        checkCount++;
        if ({aLsuStEn, aBusy, aM0Rvalid, aM1Rvalid, aLsuAddr} !== 36'b0) begin
            errorCount++;
            $display("[TB] FAIL store_done got %b addr %h expected 0", {aLsuStEn, aBusy, aM0Rvalid, aM1Rvalid}, aLsuAddr);
        end
        step();
    endtask

    // m1 signed byte load at LD_LATENCY=1; data is valid only in ACCESS.
    task automatic test_load_lat1();
        ldData = 32'hBAD0BAD0;
        applyStimulus(1, 1, 0, 32'h20, 2'b00, 0, 32'h0);
        sample();
        checkCount++;
        if ({aM0Gnt, aM1Gnt} !== 2'b01) begin
            errorCount++;
            $display("[TB] FAIL load1_gnt got %b expected 01", {aM0Gnt, aM1Gnt});
        end
        step();
        m1Req  = 1'b0;
        ldData = 32'h00000080;
        sample();
        checkCount++;
        if ({aBusy, aLsuStEn, aM1Rvalid, aLsuAddr, aLsuMode, aLsuUnsigned} !== {3'b100, 32'h20, 2'b00, 1'b0}) begin
            errorCount++;
            $display("[TB] FAIL load1_access got %b addr %h mode %b expected 100 00000020 00",
                     {aBusy, aLsuStEn, aM1Rvalid}, aLsuAddr, aLsuMode);
        end
        step();
        ldData = 32'hBAD0BAD0;
        sample();
        checkCount++;
        if ({aM1Rvalid, aM0Rvalid, aBusy} !== 3'b100) begin
            errorCount++;
            $display("[TB] FAIL load1_rvalid got %b expected 100", {aM1Rvalid, aM0Rvalid, aBusy});
        end
        checkCount++;
        if (aM1Rdata !== 32'h00000080) begin
            errorCount++;
            $display("[TB] FAIL load1_rdata got %h expected 00000080", aM1Rdata);
        end
        step();
        sample();
        checkCount++;
        if ({aM1Rvalid, aM1Rdata} !== {1'b0, 32'h00000080}) begin
            errorCount++;
            $display("[TB] FAIL load1_hold got %b %h expected 0 00000080", aM1Rvalid, aM1Rdata);
        end
        step();
        step();
        step();
    endtask

    // Both ports keep requesting stores for four accesses.
    task automatic test_arbitration();
        logic [1:0] expGnt [4];
`ifdef LSU_ARB_ROUND_ROBIN_EN
        expGnt = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        expGnt = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
        applyStimulus(0, 1, 1, 32'h100, 2'b10, 0, 32'h11111111);
        applyStimulus(1, 1, 1, 32'h200, 2'b10, 0, 32'h22222222);
        for (int i = 0; i < 4; i++) begin
            sample();
            checkCount++;
            if ({aM0Gnt, aM1Gnt} !== expGnt[i]) begin
                errorCount++;
                $display("[TB] FAIL arb_gnt[%0d] got %b expected %b", i, {aM0Gnt, aM1Gnt}, expGnt[i]);
            end
            step();
            sample();
            checkCount++;
            if ({aM0Gnt, aM1Gnt, aLsuStEn, aLsuAddr} !==
                {3'b001, (expGnt[i] == 2'b10) ? 32'h100 : 32'h200}) begin
                errorCount++;
                $display("[TB] FAIL arb_access[%0d] got %b addr %h", i, {aM0Gnt, aM1Gnt, aLsuStEn}, aLsuAddr);
            end
            step();
        end
        m0Req = 1'b0;
        m1Req = 1'b0;
        step();
    endtask

    // m0 unsigned word load on the LD_LATENCY=3 instance.
    task automatic test_latency3();
        ldData = 32'hBAD0BAD0;
        applyStimulus(0, 1, 0, 32'h40, 2'b10, 1, 32'h0);
        sample();
        checkCount++;
        if ({bM0Gnt, bM1Gnt} !== 2'b10) begin
            errorCount++;
            $display("[TB] FAIL lat3_gnt got %b expected 10", {bM0Gnt, bM1Gnt});
        end
        step();
        m0Req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) ldData = 32'h12345678;
            sample();
            checkCount++;
            if ({bBusy, bM0Rvalid, bLsuAddr} !== {2'b10, 32'h40}) begin
                errorCount++;
                $display("[TB] FAIL lat3_busy[%0d] got %b addr %h expected 10 00000040",
                         i, {bBusy, bM0Rvalid}, bLsuAddr);
            end
            step();
        end
        ldData = 32'hBAD0BAD0;
        sample();
        checkCount++;
        if ({bBusy, bM0Rvalid, bM0Rdata, bLsuAddr} !== {2'b01, 32'h12345678, 32'h0}) begin
            errorCount++;
            $display("[TB] FAIL lat3_rvalid got %b data %h addr %h expected 01 12345678 00000000",
                     {bBusy, bM0Rvalid}, bM0Rdata, bLsuAddr);
        end
        step();
        sample();
        checkCount++;
        if (bM0Rvalid !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL lat3_pulse got %b expected 0", bM0Rvalid);
        end
        step();
    endtask

    // Requests raised while busy wait for IDLE; a request withdrawn first
    // never reaches the LSU. The late request also checks mode 11 passthrough.
    task automatic test_busy_req();
        applyStimulus(0, 1, 1, 32'h300, 2'b10, 0, 32'hAAAA5555);
        sample();
        step();
        m0Req = 1'b0;
        applyStimulus(1, 1, 1, 32'h83, 2'b11, 1, 32'h0F0F0F0F);
        sample();
        checkCount++;
        if ({aM0Gnt, aM1Gnt, aLsuStEn, aBusy, aLsuAddr} !== {4'b0011, 32'h300}) begin
            errorCount++;
            $display("[TB] FAIL busy_no_gnt got %b addr %h expected 0011 00000300",
                     {aM0Gnt, aM1Gnt, aLsuStEn, aBusy}, aLsuAddr);
        end
        step();
        sample();
        checkCount++;
        if ({aM1Gnt, aBusy} !== 2'b10) begin
            errorCount++;
            $display("[TB] FAIL busy_gnt_after_idle got %b expected 10", {aM1Gnt, aBusy});
        end
        step();
        m1Req = 1'b0;
        sample();
        checkCount++;
        if ({aLsuStEn, aLsuAddr, aLsuMode, aLsuUnsigned, aLsuStData} !==
            {1'b1, 32'h83, 2'b11, 1'b1, 32'h0F0F0F0F}) begin
            errorCount++;
            $display("[TB] FAIL passthrough_mode11 got %b %h %b %b %h expected 1 00000083 11 1 0f0f0f0f",
                     aLsuStEn, aLsuAddr, aLsuMode, aLsuUnsigned, aLsuStData);
        end
        step();

        applyStimulus(0, 1, 1, 32'h304, 2'b10, 0, 32'h55AA55AA);
        sample();
        step();
        m0Req = 1'b0;
        m1Req = 1'b1;
        sample();
        checkCount++;
        if (aM1Gnt !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL busy_drop_no_gnt got %b expected 0", aM1Gnt);
        end
        step();
        m1Req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            checkCount++;
            if ({aM1Gnt, aLsuStEn, aBusy, bLsuStEn} !== 4'b0) begin
                errorCount++;
                $display("[TB] FAIL dropped_req[%0d] got %b expected 0000", i, {aM1Gnt, aLsuStEn, aBusy, bLsuStEn});
            end
            step();
        end
    endtask

    // Reset aborts a store and a load in WAIT, and re-arms m0 tie priority.
    task automatic test_reset_wait();
        applyStimulus(0, 1, 1, 32'h400, 2'b10, 0, 32'h13579BDF);
        sample();
        step();
        m0Req = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        checkCount++;
        if ({aLsuStEn, aBusy, bLsuStEn, bBusy, aLsuAddr} !== 36'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_store_abort got %b addr %h expected 0", {aLsuStEn, aBusy, bLsuStEn, bBusy}, aLsuAddr);
        end
        step();
        resetN = 1'b1;
        step();

        ldData = 32'hCAFEF00D;
        applyStimulus(0, 1, 0, 32'h50, 2'b10, 0, 32'h0);
        sample();
        step();
        m0Req = 1'b0;
        step();
        #2;
        resetN = 1'b0;
        #1;
        checkCount++;
        if ({bBusy, bLsuStEn, bM0Rvalid, bM0Gnt, bLsuAddr, bLsuMode, bM0Rdata} !== 70'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_wait_clear got %b addr %h rdata %h expected 0",
                     {bBusy, bLsuStEn, bM0Rvalid, bM0Gnt}, bLsuAddr, bM0Rdata);
        end
        for (int i = 0; i < 2; i++) begin
            sample();
            checkCount++;
            if ({bM0Rvalid, bM1Rvalid, bBusy, aM0Rvalid, aBusy} !== 5'b0) begin
                errorCount++;
                $display("[TB] FAIL reset_no_rvalid[%0d] got %b expected 0",
                         i, {bM0Rvalid, bM1Rvalid, bBusy, aM0Rvalid, aBusy});
            end
            step();
        end
        resetN = 1'b1;
        step();

        applyStimulus(0, 1, 1, 32'h500, 2'b10, 0, 32'h1);
        applyStimulus(1, 1, 1, 32'h600, 2'b10, 0, 32'h2);
        sample();
        checkCount++;
        if ({aM0Gnt, aM1Gnt, bM0Gnt, bM1Gnt} !== 4'b1010) begin
            errorCount++;
            $display("[TB] FAIL reset_tie_m0 got %b expected 1010", {aM0Gnt, aM1Gnt, bM0Gnt, bM1Gnt});
        end
        step();
        m0Req = 1'b0;
        m1Req = 1'b0;
        step();
        step();
    endtask

    initial begin
        resetN = 1'b0;
        ldData = 32'h0;
        applyStimulus(0, 0, 0, 32'h0, 2'b00, 0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 2'b00, 0, 32'h0);
        $display("[TB] start");
        test_reset();
        test_store();
        test_load_lat1();
        test_arbitration();
        test_latency3();
        test_busy_req();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence ended");
        $fatal(1, "[TB] watchdog");
    end

endmodule
